gray_scale_pipe: RTL and testbench

Parametrised, handshaked successor to the single-mode gray-scale core: converts packed RGB pixels of configurable channel depth into OUT_W-bit gray values using one of four run-time conversion modes. Sits between the pixel source and the Sobel window buffer, and replaces the free-running conversion path with a valid/ready stream that tolerates back-pressure. It counts pixels per frame, flags the last pixel, and signals frame completion.

---
 rtl/gray_scale_pipe.sv | 148 ++++++++++++++
 tb/tb_gray_scale_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_scale_pipe.sv
// Handshaked RGB-to-gray converter with four run-time modes, per-frame pixel
// counting, last-pixel tagging and a frame-complete pulse.
module gray_scale_pipe #(
    parameter int unsigned CH_BITS      = 5,
    parameter int unsigned OUT_W        = 8,
    parameter int unsigned FRAME_PIXELS = 16,
    localparam int unsigned CNT_W       = $clog2(FRAME_PIXELS + 1),
    localparam int unsigned IN_W        = 3 * CH_BITS
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             finish_i,
    input  logic [1:0]       mode_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_px_rgb_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_px_gray_o,
    output logic             out_last_o,
    output logic [CNT_W-1:0] pixel_count_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int unsigned SHIFT = OUT_W - CH_BITS;
    localparam int unsigned SUM_W = OUT_W + 2;
    localparam int unsigned MUL_W = OUT_W + 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_n;

    logic             en;
    logic             accept;
    logic             hit;
    logic [CNT_W-1:0] cnt_plus;
    logic [1:0]       mode_q;

    logic             s1_valid;
    logic             s1_last;
    logic [OUT_W-1:0] s1_r, s1_g, s1_b;
    logic [OUT_W-1:0] exp_r, exp_g, exp_b;

    logic [SUM_W-1:0] luma, sum3, res;
    logic [MUL_W-1:0] mean_prod;
    logic [OUT_W-1:0] mx, gray_c;

    assign en         = !out_valid_o || out_ready_i;
    assign in_ready_o = (state == RUN) && en;
    assign accept     = in_valid_i && in_ready_o;
    assign cnt_plus   = pixel_count_o + CNT_W'(1);
    assign hit        = (cnt_plus == CNT_W'(FRAME_PIXELS));

    // Zero-filled channel expansion to OUT_W bits
    assign exp_r = OUT_W'(in_px_rgb_i[IN_W-1 -: CH_BITS]) << SHIFT;
    assign exp_g = OUT_W'(in_px_rgb_i[2*CH_BITS-1 -: CH_BITS]) << SHIFT;
    assign exp_b = OUT_W'(in_px_rgb_i[CH_BITS-1:0]) << SHIFT;

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_i) state_n = RUN;
            RUN:     if (finish_i || (accept && hit)) state_n = DRAIN;
            DRAIN:   if (!s1_valid && !out_valid_o) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Frame bookkeeping: mode latch, pixel counter, status flags
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q        <= 2'd0;
            pixel_count_o <= '0;
            done_o        <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                mode_q        <= mode_i;
                pixel_count_o <= '0;
            end else if (accept) begin
                pixel_count_o <= cnt_plus;
            end
            done_o <= (state == DRAIN) && (state_n == IDLE);
            busy_o <= (state_n != IDLE);
        end
    end

    // Stage 1: expanded channels with valid/last
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else if (en) begin
            s1_valid <= accept;
            s1_last  <= accept && (hit || finish_i);
            if (accept) begin
                s1_r <= exp_r;
                s1_g <= exp_g;
                s1_b <= exp_b;
            end
        end
    end

    always_comb begin
        luma = SUM_W'(s1_r >> 2) + SUM_W'(s1_r >> 5) + SUM_W'(s1_g >> 1)
             + SUM_W'(s1_g >> 4) + SUM_W'(s1_b >> 4) + SUM_W'(s1_b >> 5);
        sum3      = SUM_W'(s1_r) + SUM_W'(s1_g) + SUM_W'(s1_b);
        mean_prod = MUL_W'(sum3) * MUL_W'(85);
        mx        = s1_r;
        if (s1_g > mx) mx = s1_g;
        if (s1_b > mx) mx = s1_b;
        case (mode_q)
            2'd0:    res = luma;
            2'd1:    res = SUM_W'(mean_prod >> 8);
            2'd2:    res = SUM_W'(mx);
            default: res = SUM_W'(s1_g);
        endcase
        gray_c = (res > SUM_W'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : res[OUT_W-1:0];
    end

    // Stage 2: converted result; gray value holds across bubbles
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_valid_o   <= 1'b0;
            out_last_o    <= 1'b0;
            out_px_gray_o <= '0;
        end else if (en) begin
            out_valid_o <= s1_valid;
            out_last_o  <= s1_valid && s1_last;
            if (s1_valid) out_px_gray_o <= gray_c;
        end
    end

endmodule

// File: tb/tb_gray_scale_pipe.sv
// Directed bench for gray_scale_pipe: modes, framing, back-pressure, abort and reset.
module tb_gray_scale_pipe;

    localparam int unsigned CH = 5;
    localparam int unsigned OW = 8;
    localparam int unsigned FP = 4;
    localparam int unsigned CW = $clog2(FP + 1);

    logic          clk_i;
    logic          reset_i;
    logic          start_i;
    logic          finish_i;
    logic [1:0]    mode_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [3*CH-1:0] in_px_rgb_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [OW-1:0] out_px_gray_o;
    logic          out_last_o;
    logic [CW-1:0] pixel_count_o;
    logic          done_o;
    logic          busy_o;

    int total = 0;
    int bad   = 0;
    logic [8:0] q[$];

    gray_scale_pipe #(.CH_BITS(CH), .OUT_W(OW), .FRAME_PIXELS(FP)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .finish_i(finish_i),
        .mode_i(mode_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_px_rgb_i(in_px_rgb_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_px_gray_o(out_px_gray_o), .out_last_o(out_last_o),
        .pixel_count_o(pixel_count_o), .done_o(done_o), .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Record every completed output transfer as {last, gray}
    always @(negedge clk_i)
        if (!reset_i && out_valid_o && out_ready_i) q.push_back({out_last_o, out_px_gray_o});

    function automatic logic [3*CH-1:0] rgb(input int r, input int g, input int b);
        logic [CH-1:0] rr, gg, bb;
        rr = CH'(r); gg = CH'(g); bb = CH'(b);
        return {rr, gg, bb};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int idx, input logic [8:0] exp);
        logic [8:0] v;
        v = (idx < q.size()) ? q[idx] : 9'h1FF;
        chk(tag, 32'(v), 32'(exp));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_o && n < 20) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_o), 32'd1);
        tick();
        chk("done_pulse_end", 32'(done_o), 32'd0);
        chk("busy_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic run_one(input logic [1:0] mode, input int r, input int g, input int b,
                           input logic [7:0] exp);
        q.delete();
        start_i = 1'b1; mode_i = mode;
        tick();
        start_i = 1'b0; mode_i = mode ^ 2'b01;
        in_valid_i = 1'b1; in_px_rgb_i = rgb(r, g, b); finish_i = 1'b1;
        tick();
        in_valid_i = 1'b0; finish_i = 1'b0;
        wait_done();
        chk("one_size", 32'(q.size()), 32'd1);
        chk_q("one_gray_last", 0, {1'b1, exp});
        chk("one_count", 32'(pixel_count_o), 32'd1);
    endtask

    initial begin
        int idx;
        logic acc;
        logic [7:0] hold;

        reset_i = 1'b1; start_i = 1'b0; finish_i = 1'b0; mode_i = 2'd0;
        in_valid_i = 1'b0; in_px_rgb_i = '0; out_ready_i = 1'b1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_gray", 32'(out_px_gray_o), 32'd0);
        chk("rst_count", 32'(pixel_count_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        reset_i = 1'b0;
        tick();

        // Mode 0 luma, two pixels with finish on the second, latency and done timing
        start_i = 1'b1; mode_i = 2'd0;
        tick();
        start_i = 1'b0;
        chk("a_busy", 32'(busy_o), 32'd1);
        chk("a_in_ready", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1; in_px_rgb_i = rgb(31, 31, 31); mode_i = 2'd3;
        tick();
        chk("a_lat_not_yet", 32'(out_valid_o), 32'd0);
        in_px_rgb_i = rgb(16, 0, 0); finish_i = 1'b1;
        tick();
        in_valid_i = 1'b0; finish_i = 1'b0;
        chk("a_out1_valid", 32'(out_valid_o), 32'd1);
        chk("a_out1_gray", 32'(out_px_gray_o), 32'd230);
        chk("a_out1_last", 32'(out_last_o), 32'd0);
        chk("a_count", 32'(pixel_count_o), 32'd2);
        chk("a_drain_ready", 32'(in_ready_o), 32'd0);
        tick();
        chk("a_out2_gray", 32'(out_px_gray_o), 32'd36);
        chk("a_out2_last", 32'(out_last_o), 32'd1);
        tick();
        chk("a_empty", 32'(out_valid_o), 32'd0);
        chk("a_gray_hold", 32'(out_px_gray_o), 32'd36);
        chk("a_done_early", 32'(done_o), 32'd0);
        tick();
        chk("a_done", 32'(done_o), 32'd1);
        chk("a_busy_low", 32'(busy_o), 32'd0);
        tick();
        chk("a_done_once", 32'(done_o), 32'd0);
        chk("a_count_hold", 32'(pixel_count_o), 32'd2);

        run_one(2'd1, 31, 31, 31, 8'd247);
        run_one(2'd2, 31, 0, 10, 8'd248);
        run_one(2'd3, 0, 16, 0, 8'd128);

        // Full frame of FP pixels, continuous valid
        q.delete();
        start_i = 1'b1; mode_i = 2'd3;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1; in_px_rgb_i = rgb(0, i + 1, 0);
            #1;
            chk("e_ready", 32'(in_ready_o), 32'd1);
            tick();
        end
        in_px_rgb_i = rgb(0, 9, 0);
        #1;
        chk("e_ready_low", 32'(in_ready_o), 32'd0);
        tick();
        chk("e_ready_low2", 32'(in_ready_o), 32'd0);
        in_valid_i = 1'b0;
        wait_done();
        chk("e_count", 32'(pixel_count_o), 32'd4);
        chk("e_size", 32'(q.size()), 32'd4);
        chk_q("e_q0", 0, 9'd8);
        chk_q("e_q1", 1, 9'd16);
        chk_q("e_q2", 2, 9'd24);
        chk_q("e_q3", 3, {1'b1, 8'd32});

        // Back-pressure for 5 cycles mid-stream
        q.delete();
        start_i = 1'b1; mode_i = 2'd3;
        tick();
        start_i = 1'b0;
        idx = 0; hold = '0;
        for (int c = 0; c < 40; c++) begin
            out_ready_i = !(c >= 3 && c < 8);
            in_valid_i = (idx < 4);
            in_px_rgb_i = rgb(0, idx + 5, 0);
            #1;
            acc = in_valid_i && in_ready_o;
            if (c == 3) hold = out_px_gray_o;
            if (c >= 3 && c < 8) begin
                chk("f_stall_ready", 32'(in_ready_o), 32'd0);
                chk("f_stall_valid", 32'(out_valid_o), 32'd1);
                chk("f_stall_gray", 32'(out_px_gray_o), 32'(hold));
            end
            if (done_o) break;
            tick();
            if (acc) idx++;
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        chk("f_done", 32'(done_o), 32'd1);
        tick();
        chk("f_count", 32'(pixel_count_o), 32'd4);
        chk("f_size", 32'(q.size()), 32'd4);
        chk_q("f_q0", 0, 9'd40);
        chk_q("f_q1", 1, 9'd48);
        chk_q("f_q2", 2, 9'd56);
        chk_q("f_q3", 3, {1'b1, 8'd64});

        // Abort with the 2nd pixel; start during RUN is ignored
        q.delete();
        start_i = 1'b1; mode_i = 2'd3;
        tick();
        in_valid_i = 1'b1; in_px_rgb_i = rgb(0, 1, 0); start_i = 1'b1; mode_i = 2'd1;
        tick();
        start_i = 1'b0; in_px_rgb_i = rgb(0, 2, 0); finish_i = 1'b1;
        tick();
        in_valid_i = 1'b0; finish_i = 1'b0;
        chk("g_count", 32'(pixel_count_o), 32'd2);
        wait_done();
        chk("g_size", 32'(q.size()), 32'd2);
        chk_q("g_q0", 0, 9'd8);
        chk_q("g_q1", 1, {1'b1, 8'd16});
        chk("g_count_hold", 32'(pixel_count_o), 32'd2);

        // Reset with two pixels in flight
        q.delete();
        start_i = 1'b1; mode_i = 2'd3;
        tick();
        start_i = 1'b0;
        in_valid_i = 1'b1; in_px_rgb_i = rgb(0, 3, 0);
        tick();
        in_px_rgb_i = rgb(0, 4, 0);
        tick();
        in_valid_i = 1'b0; reset_i = 1'b1;
        tick();
        chk("h_out_valid", 32'(out_valid_o), 32'd0);
        chk("h_gray", 32'(out_px_gray_o), 32'd0);
        chk("h_last", 32'(out_last_o), 32'd0);
        chk("h_count", 32'(pixel_count_o), 32'd0);
        chk("h_done", 32'(done_o), 32'd0);
        chk("h_busy", 32'(busy_o), 32'd0);
        chk("h_in_ready", 32'(in_ready_o), 32'd0);
        reset_i = 1'b0;
        tick(); tick(); tick();
        chk("h_no_stale", 32'(q.size()), 32'd0);
        chk("h_valid_low", 32'(out_valid_o), 32'd0);
        run_one(2'd0, 16, 0, 0, 8'd36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
